// File: rtl/v_switch_bank_pkg.sv
// ----------------------------------------------------------------------------
// v_switch_bank_pkg
// Shared constants for the virtual switch bank: command opcodes, status codes
// returned in the acknowledge chunk, FSM state encoding and the fixed command
// payload size.
// No ports (package).
// ----------------------------------------------------------------------------
package v_switch_bank_pkg;

   // Command payload is always opcode, byte index, data
   localparam int CMD_BYTES = 3;

   localparam logic [7:0] OP_WRITE  = 8'd0;
   localparam logic [7:0] OP_SET    = 8'd1;
   localparam logic [7:0] OP_CLEAR  = 8'd2;
   localparam logic [7:0] OP_TOGGLE = 8'd3;
   localparam logic [7:0] OP_QUERY  = 8'd4;

   // STATUS_REJECT is the generic rejection code; the specific codes below
   // are what the bank reports so the host can tell the causes apart.
   localparam logic [7:0] STATUS_OK         = 8'd0;
   localparam logic [7:0] STATUS_REJECT     = 8'd1;
   localparam logic [7:0] STATUS_BAD_SIZE   = 8'd2;
   localparam logic [7:0] STATUS_BAD_OPCODE = 8'd3;
   localparam logic [7:0] STATUS_BAD_INDEX  = 8'd4;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

endpackage

// File: rtl/v_switch_byte_op.sv
// ----------------------------------------------------------------------------
// v_switch_byte_op
// Combinational byte operator applied to the one bank byte addressed by a
// command.
// Ports:
//   opcode   in  8  command opcode
//   old_byte in  8  current value of the addressed byte
//   data     in  8  command data byte
//   new_byte out 8  resulting byte (old_byte for QUERY or unknown opcodes)
// ----------------------------------------------------------------------------
module v_switch_byte_op
   import v_switch_bank_pkg::*;
(
   input  logic [7:0] opcode,
   input  logic [7:0] old_byte,
   input  logic [7:0] data,
   output logic [7:0] new_byte
);

   always_comb begin
      case (opcode)
         OP_WRITE:  new_byte = data;
         OP_SET:    new_byte = old_byte | data;
         OP_CLEAR:  new_byte = old_byte & ~data;
         OP_TOGGLE: new_byte = old_byte ^ data;
         default:   new_byte = old_byte;
      endcase
   end

endmodule

// File: rtl/v_switch_bank.sv
// ----------------------------------------------------------------------------
// v_switch_bank
// Multi-byte bank of virtual switches updated by typed RX command chunks.
// Every matching command (accepted or rejected) is answered with one TX status
// chunk carrying the status byte and the bank snapshot after the update.
// Commands arriving while an answer is still pending are dropped and counted.
// Ports:
//   CLK                 in   1    clock
//   RST                 in   1    synchronous active-high reset
//   rx_chunk_type       in   8    type of presented chunk
//   rx_chunk_bytes      in   8*RX_CONTENT_BUFFER_BYTE_SIZE  payload
//   rx_chunk_byte_size  in   RX_CONTENT_BUFFER_INDEX_SIZE   valid payload bytes
//   rx_is_chunk_ready   in   1    one-cycle chunk strobe
//   switches            out  SW   current bank value
//   switches_changed    out  1    pulse when the bank value changed
//   tx_chunk_type       out  8    constant INTERFACE_TX_CHUNK_TYPE
//   tx_chunk_bytes      out  SW+8 {bank snapshot, status}
//   tx_chunk_byte_size  out  RX_CONTENT_BUFFER_INDEX_SIZE  SWITCH_BYTES+1
//   tx_is_chunk_ready   out  1    TX valid
//   tx_chunk_accepted   in   1    TX accept
//   drop_count          out  8    saturating count of dropped commands
// ----------------------------------------------------------------------------
module v_switch_bank
   import v_switch_bank_pkg::*;
#(
   parameter int                        INTERFACE_RX_CHUNK_TYPE      = 4,
   parameter int                        INTERFACE_TX_CHUNK_TYPE      = 5,
   parameter int                        SWITCH_BYTES                 = 2,
   parameter logic [8*SWITCH_BYTES-1:0] RESET_VALUE                  = '0,
   parameter int                        RX_CONTENT_BUFFER_BYTE_SIZE  = 3,
   parameter int                        RX_CONTENT_BUFFER_INDEX_SIZE = 32
)
(
   input  logic                                     CLK,
   input  logic                                     RST,
   input  logic [7:0]                               rx_chunk_type,
   input  logic [8*RX_CONTENT_BUFFER_BYTE_SIZE-1:0] rx_chunk_bytes,
   input  logic [RX_CONTENT_BUFFER_INDEX_SIZE-1:0]  rx_chunk_byte_size,
   input  logic                                     rx_is_chunk_ready,
   output logic [8*SWITCH_BYTES-1:0]                switches,
   output logic                                     switches_changed,
   output logic [7:0]                               tx_chunk_type,
   output logic [8*SWITCH_BYTES+7:0]                tx_chunk_bytes,
   output logic [RX_CONTENT_BUFFER_INDEX_SIZE-1:0]  tx_chunk_byte_size,
   output logic                                     tx_is_chunk_ready,
   input  logic                                     tx_chunk_accepted,
   output logic [7:0]                               drop_count
);

   localparam int SW = 8 * SWITCH_BYTES;

   logic [0:0]    state;
   logic          cmd_match;
   logic [7:0]    cmd_opcode;
   logic [7:0]    cmd_index;
   logic [7:0]    cmd_data;
   logic [7:0]    cmd_status;
   logic [7:0]    old_byte;
   logic [7:0]    new_byte;
   logic [SW-1:0] next_bank;

   assign cmd_opcode = rx_chunk_bytes[7:0];
   assign cmd_index  = rx_chunk_bytes[15:8];
   assign cmd_data   = rx_chunk_bytes[23:16];
   assign cmd_match  = rx_is_chunk_ready &&
                       (rx_chunk_type == 8'(INTERFACE_RX_CHUNK_TYPE));

   assign tx_chunk_type      = 8'(INTERFACE_TX_CHUNK_TYPE);
   assign tx_chunk_byte_size = RX_CONTENT_BUFFER_INDEX_SIZE'(SWITCH_BYTES + 1);
   assign tx_is_chunk_ready  = (state == ST_ACK);

   // Validation order decides which code wins when several checks fail:
   // size first, then opcode, then index. QUERY ignores the index byte.
   always_comb begin
      if (rx_chunk_byte_size != RX_CONTENT_BUFFER_INDEX_SIZE'(CMD_BYTES))
         cmd_status = STATUS_BAD_SIZE;
      else if (cmd_opcode > OP_QUERY)
         cmd_status = STATUS_BAD_OPCODE;
      else if ((cmd_opcode != OP_QUERY) && (cmd_index >= 8'(SWITCH_BYTES)))
         cmd_status = STATUS_BAD_INDEX;
      else
         cmd_status = STATUS_OK;
   end

   // Byte lane selection is a compare-per-lane mux so an out-of-range index
   // never produces an out-of-bounds part select.
   always_comb begin
      old_byte = 8'h00;
      for (int k = 0; k < SWITCH_BYTES; k++) begin
         if (cmd_index == 8'(k))
            old_byte = switches[8*k +: 8];
      end
   end

   v_switch_byte_op u_byte_op (
      .opcode   (cmd_opcode),
      .old_byte (old_byte),
      .data     (cmd_data),
      .new_byte (new_byte)
   );

   // Only a fully valid, non-QUERY command modifies its lane.
   always_comb begin
      next_bank = switches;
      if ((cmd_status == STATUS_OK) && (cmd_opcode != OP_QUERY)) begin
         for (int k = 0; k < SWITCH_BYTES; k++) begin
            if (cmd_index == 8'(k))
               next_bank[8*k +: 8] = new_byte;
         end
      end
   end

   // IDLE applies a command and latches the answer; ACK holds the answer until
   // accepted and drops any command that shows up meanwhile, including one in
   // the accept cycle itself.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state            <= ST_IDLE;
         switches         <= RESET_VALUE;
         switches_changed <= 1'b0;
         tx_chunk_bytes   <= '0;
         drop_count       <= 8'h00;
      end else begin
         switches_changed <= 1'b0;
         if (state == ST_IDLE) begin
            if (cmd_match) begin
               switches         <= next_bank;
               switches_changed <= (next_bank != switches);
               tx_chunk_bytes   <= {next_bank, cmd_status};
               state            <= ST_ACK;
            end
         end else begin
            if (cmd_match && (drop_count != 8'hFF))
               drop_count <= drop_count + 8'd1;
            if (tx_chunk_accepted)
               state <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_v_switch_bank.sv
// ----------------------------------------------------------------------------
// tb_v_switch_bank
// Self-checking bench for v_switch_bank with SWITCH_BYTES=2, RESET_VALUE=0.
// ----------------------------------------------------------------------------
module tb_v_switch_bank;

   logic        CLK;
   logic        RST;
   logic [7:0]  rx_chunk_type;
   logic [23:0] rx_chunk_bytes;
   logic [31:0] rx_chunk_byte_size;
   logic        rx_is_chunk_ready;
   logic [15:0] switches;
   logic        switches_changed;
   logic [7:0]  tx_chunk_type;
   logic [23:0] tx_chunk_bytes;
   logic [31:0] tx_chunk_byte_size;
   logic        tx_is_chunk_ready;
   logic        tx_chunk_accepted;
   logic [7:0]  drop_count;

   int checks   = 0;
   int failures = 0;

   logic [23:0] scoreboard[$];

   typedef struct {
      logic [7:0]  op;
      logic [7:0]  idx;
      logic [7:0]  data;
      logic [31:0] size;
      logic [15:0] exp_sw;
      logic        exp_chg;
      logic [7:0]  exp_status;
   } vec_t;

   vec_t vectors[13];

   v_switch_bank #(
      .INTERFACE_RX_CHUNK_TYPE      (4),
      .INTERFACE_TX_CHUNK_TYPE      (5),
      .SWITCH_BYTES                 (2),
      .RESET_VALUE                  (16'h0000),
      .RX_CONTENT_BUFFER_BYTE_SIZE  (3),
      .RX_CONTENT_BUFFER_INDEX_SIZE (32)
   ) dut (
      .CLK                (CLK),
      .RST                (RST),
      .rx_chunk_type      (rx_chunk_type),
      .rx_chunk_bytes     (rx_chunk_bytes),
      .rx_chunk_byte_size (rx_chunk_byte_size),
      .rx_is_chunk_ready  (rx_is_chunk_ready),
      .switches           (switches),
      .switches_changed   (switches_changed),
      .tx_chunk_type      (tx_chunk_type),
      .tx_chunk_bytes     (tx_chunk_bytes),
      .tx_chunk_byte_size (tx_chunk_byte_size),
      .tx_is_chunk_ready  (tx_is_chunk_ready),
      .tx_chunk_accepted  (tx_chunk_accepted),
      .drop_count         (drop_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Global time bound so a stuck run still ends with a report.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] actual,
                        input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Presents one chunk for exactly one clock edge; called #1 after an edge.
   task automatic applyStimulus(input logic [7:0] ctype, input logic [7:0] op,
                                input logic [7:0] idx, input logic [7:0] data,
                                input logic [31:0] size);
      rx_chunk_type      = ctype;
      rx_chunk_bytes     = {data, idx, op};
      rx_chunk_byte_size = size;
      rx_is_chunk_ready  = 1'b1;
      @(posedge CLK);
      #1;
      rx_is_chunk_ready  = 1'b0;
   endtask

   // Waits (bounded) for a pending ack, compares it with the oldest
   // scoreboard entry, then accepts it and checks the valid drops.
   task automatic checkOutput(input string name);
      logic [23:0] expected;
      int          waited;
      waited = 0;
      while (!tx_is_chunk_ready && waited < 20) begin
         @(posedge CLK);
         #1;
         waited++;
      end
      if (scoreboard.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_scoreboard actual=empty required=entry", name);
         return;
      end
      expected = scoreboard.pop_front();
      check({name, "_tx_valid"}, 64'(tx_is_chunk_ready), 64'd1);
      check({name, "_tx_bytes"}, 64'(tx_chunk_bytes), 64'(expected));
      tx_chunk_accepted = 1'b1;
      @(posedge CLK);
      #1;
      tx_chunk_accepted = 1'b0;
      check({name, "_tx_released"}, 64'(tx_is_chunk_ready), 64'd0);
   endtask

   initial begin
      logic stable;

      RST                = 1'b1;
      rx_chunk_type      = 8'd0;
      rx_chunk_bytes     = 24'd0;
      rx_chunk_byte_size = 32'd0;
      rx_is_chunk_ready  = 1'b0;
      tx_chunk_accepted  = 1'b0;

      //                op     idx    data   size   exp_sw    chg   status
      vectors[0]  = '{8'd0, 8'd1, 8'hA5, 32'd3, 16'hA500, 1'b1, 8'd0};
      vectors[1]  = '{8'd1, 8'd0, 8'h0F, 32'd3, 16'hA50F, 1'b1, 8'd0};
      vectors[2]  = '{8'd2, 8'd0, 8'h03, 32'd3, 16'hA50C, 1'b1, 8'd0};
      vectors[3]  = '{8'd3, 8'd0, 8'hFF, 32'd3, 16'hA5F3, 1'b1, 8'd0};
      vectors[4]  = '{8'd0, 8'd0, 8'hF3, 32'd3, 16'hA5F3, 1'b0, 8'd0};
      vectors[5]  = '{8'd4, 8'd9, 8'h77, 32'd3, 16'hA5F3, 1'b0, 8'd0};
      vectors[6]  = '{8'd0, 8'd0, 8'h00, 32'd2, 16'hA5F3, 1'b0, 8'd2};
      vectors[7]  = '{8'd7, 8'd0, 8'h00, 32'd3, 16'hA5F3, 1'b0, 8'd3};
      vectors[8]  = '{8'd1, 8'd2, 8'hFF, 32'd3, 16'hA5F3, 1'b0, 8'd4};
      vectors[9]  = '{8'd7, 8'd5, 8'h00, 32'd2, 16'hA5F3, 1'b0, 8'd2};
      vectors[10] = '{8'd9, 8'd5, 8'h00, 32'd3, 16'hA5F3, 1'b0, 8'd3};
      vectors[11] = '{8'd3, 8'd1, 8'h0F, 32'd3, 16'hAAF3, 1'b1, 8'd0};
      vectors[12] = '{8'd2, 8'd1, 8'hFF, 32'd3, 16'h00F3, 1'b1, 8'd0};

      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;

      $display("[TB] reset values");
      check("rst_switches", 64'(switches), 64'h0);
      check("rst_changed", 64'(switches_changed), 64'h0);
      check("rst_tx_valid", 64'(tx_is_chunk_ready), 64'h0);
      check("rst_tx_bytes", 64'(tx_chunk_bytes), 64'h0);
      check("rst_drop_count", 64'(drop_count), 64'h0);
      check("tx_type", 64'(tx_chunk_type), 64'd5);
      check("tx_size", 64'(tx_chunk_byte_size), 64'd3);

      $display("[TB] non-matching chunk type");
      applyStimulus(8'd3, 8'd0, 8'd0, 8'h55, 32'd3);
      check("foreign_switches", 64'(switches), 64'h0);
      check("foreign_changed", 64'(switches_changed), 64'h0);
      check("foreign_tx_valid", 64'(tx_is_chunk_ready), 64'h0);

      $display("[TB] command table");
      for (int i = 0; i < 13; i++) begin
         applyStimulus(8'd4, vectors[i].op, vectors[i].idx, vectors[i].data,
                       vectors[i].size);
         scoreboard.push_back({vectors[i].exp_sw, vectors[i].exp_status});
         check($sformatf("vec%0d_switches", i), 64'(switches), 64'(vectors[i].exp_sw));
         check($sformatf("vec%0d_changed", i), 64'(switches_changed),
               64'(vectors[i].exp_chg));
         checkOutput($sformatf("vec%0d", i));
         check($sformatf("vec%0d_pulse_end", i), 64'(switches_changed), 64'h0);
      end

      $display("[TB] command in accept cycle is dropped");
      applyStimulus(8'd4, 8'd4, 8'd0, 8'd0, 32'd3);
      scoreboard.push_back({16'h00F3, 8'd0});
      check("query_switches", 64'(switches), 64'h00F3);
      check("query_tx_valid", 64'(tx_is_chunk_ready), 64'd1);
      check("query_tx_bytes", 64'(tx_chunk_bytes), 64'(scoreboard.pop_front()));
      rx_chunk_bytes     = {8'hFF, 8'd1, 8'd1};
      rx_chunk_byte_size = 32'd3;
      rx_is_chunk_ready  = 1'b1;
      tx_chunk_accepted  = 1'b1;
      @(posedge CLK);
      #1;
      rx_is_chunk_ready  = 1'b0;
      tx_chunk_accepted  = 1'b0;
      check("acc_drop_tx_valid", 64'(tx_is_chunk_ready), 64'd0);
      check("acc_drop_switches", 64'(switches), 64'h00F3);
      check("acc_drop_count", 64'(drop_count), 64'd1);

      $display("[TB] 300 commands with accept held low");
      rx_chunk_bytes    = {8'h11, 8'd0, 8'd0};
      rx_is_chunk_ready = 1'b1;
      @(posedge CLK);
      #1;
      scoreboard.push_back({16'h0011, 8'd0});
      check("burst_first_switches", 64'(switches), 64'h0011);
      check("burst_first_changed", 64'(switches_changed), 64'd1);
      rx_chunk_bytes = {8'hFF, 8'd1, 8'd1};
      stable = 1'b1;
      for (int i = 0; i < 299; i++) begin
         @(posedge CLK);
         #1;
         if (tx_chunk_bytes !== 24'h001100 || tx_is_chunk_ready !== 1'b1)
            stable = 1'b0;
      end
      rx_is_chunk_ready = 1'b0;
      check("burst_payload_stable", 64'(stable), 64'd1);
      check("burst_drop_count", 64'(drop_count), 64'd255);
      check("burst_switches", 64'(switches), 64'h0011);
      check("burst_changed", 64'(switches_changed), 64'd0);
      checkOutput("burst");

      $display("[TB] reset while ack pending");
      applyStimulus(8'd4, 8'd0, 8'd1, 8'h3C, 32'd3);
      check("pre_rst_switches", 64'(switches), 64'h3C11);
      check("pre_rst_tx_valid", 64'(tx_is_chunk_ready), 64'd1);
      RST               = 1'b1;
      rx_chunk_bytes    = {8'hFF, 8'd0, 8'd1};
      rx_is_chunk_ready = 1'b1;
      @(posedge CLK);
      #1;
      rx_is_chunk_ready = 1'b0;
      RST               = 1'b0;
      check("ack_rst_tx_valid", 64'(tx_is_chunk_ready), 64'd0);
      check("ack_rst_switches", 64'(switches), 64'h0);
      check("ack_rst_tx_bytes", 64'(tx_chunk_bytes), 64'h0);
      check("ack_rst_drop_count", 64'(drop_count), 64'h0);
      check("ack_rst_changed", 64'(switches_changed), 64'h0);

      $display("[TB] first command after reset");
      applyStimulus(8'd4, 8'd1, 8'd0, 8'h80, 32'd3);
      scoreboard.push_back({16'h0080, 8'd0});
      check("post_rst_switches", 64'(switches), 64'h0080);
      checkOutput("post_rst");

      check("scoreboard_empty", 64'(scoreboard.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
